// File: rtl/mips_pipe_datapath.sv
// Four-stage (IF/ID/EX/WB) pipelined integer datapath with internal register file and forwarding.
// Optional SLL/SRL support is enabled by defining MIPS_PIPE_SHIFT_EN.
module mips_pipe_datapath #(
    parameter int DW       = 32,
    parameter int PC_W     = 32,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pc_out,
    output logic            wb_valid,
    output logic [4:0]      wb_reg,
    output logic [DW-1:0]   result
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

    logic [PC_W-1:0] pc;

    logic            ifid_valid;
    logic [31:0]     ifid_instr;

    logic [5:0]      id_op;
    logic [5:0]      id_funct;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [15:0]     id_imm;
    alu_op_t         id_alu;
    logic            id_write;
    logic            id_use_imm;
    logic [4:0]      id_dest;
    logic [DW-1:0]   id_a;
    logic [DW-1:0]   id_b;
    logic [DW-1:0]   id_imm_ext;

    logic            idex_write;
    logic            idex_use_imm;
    alu_op_t         idex_alu;
    logic [4:0]      idex_rs;
    logic [4:0]      idex_rt;
    logic [4:0]      idex_dest;
    logic [DW-1:0]   idex_a;
    logic [DW-1:0]   idex_b;
    logic [DW-1:0]   idex_imm;

    logic [DW-1:0]   ex_a;
    logic [DW-1:0]   ex_b;
    logic [DW-1:0]   ex_opb;
    logic [DW-1:0]   ex_res;

    logic [DW-1:0]   wb_data;
    logic [DW-1:0]   rf [32];

    assign id_op      = ifid_instr[31:26];
    assign id_rs      = ifid_instr[25:21];
    assign id_rt      = ifid_instr[20:16];
    assign id_rd      = ifid_instr[15:11];
    assign id_funct   = ifid_instr[5:0];
    assign id_imm     = ifid_instr[15:0];
    assign id_imm_ext = DW'($signed(id_imm));

    // Instructions that would target $0 decode as no-writes, so WB never claims $0.
    always_comb begin
        id_alu     = ALU_ADD;
        id_write   = 1'b0;
        id_use_imm = 1'b0;
        id_dest    = id_rd;
        if (ifid_valid) begin
            if (id_op == 6'h00) begin
                case (id_funct)
                    6'h20: begin id_write = 1'b1; id_alu = ALU_ADD; end
                    6'h22: begin id_write = 1'b1; id_alu = ALU_SUB; end
                    6'h24: begin id_write = 1'b1; id_alu = ALU_AND; end
                    6'h25: begin id_write = 1'b1; id_alu = ALU_OR;  end
                    6'h2A: begin id_write = 1'b1; id_alu = ALU_SLT; end
`ifdef MIPS_PIPE_SHIFT_EN
                    6'h00: begin id_write = 1'b1; id_alu = ALU_SLL; end
                    6'h02: begin id_write = 1'b1; id_alu = ALU_SRL; end
`endif
                    default: id_write = 1'b0;
                endcase
            end else if (id_op == 6'h08) begin
                id_write   = 1'b1;
                id_use_imm = 1'b1;
                id_alu     = ALU_ADD;
                id_dest    = id_rt;
            end
        end
        if (id_dest == 5'd0) begin
            id_write = 1'b0;
        end
    end

    // Register read with write-through of the value being written back this cycle.
    always_comb begin
        id_a = '0;
        id_b = '0;
        if (id_rs != 5'd0) begin
            id_a = (wb_valid && wb_reg == id_rs) ? wb_data : rf[id_rs];
        end
        if (id_rt != 5'd0) begin
            id_b = (wb_valid && wb_reg == id_rt) ? wb_data : rf[id_rt];
        end
    end

    // wb_valid already excludes $0, so a match here is always a genuine producer.
    always_comb begin
        ex_a   = (wb_valid && wb_reg == idex_rs) ? wb_data : idex_a;
        ex_b   = (wb_valid && wb_reg == idex_rt) ? wb_data : idex_b;
        ex_opb = idex_use_imm ? idex_imm : ex_b;
    end

    always_comb begin
        ex_res = '0;
        case (idex_alu)
            ALU_ADD: ex_res = ex_a + ex_opb;
            ALU_SUB: ex_res = ex_a - ex_opb;
            ALU_AND: ex_res = ex_a & ex_opb;
            ALU_OR:  ex_res = ex_a | ex_opb;
            ALU_SLT: ex_res = DW'($signed(ex_a) < $signed(ex_opb));
`ifdef MIPS_PIPE_SHIFT_EN
            ALU_SLL: ex_res = (int'(idex_imm[10:6]) >= DW) ? '0 : (ex_b << idex_imm[10:6]);
            ALU_SRL: ex_res = (int'(idex_imm[10:6]) >= DW) ? '0 : (ex_b >> idex_imm[10:6]);
`endif
            default: ex_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= PC_W'(RESET_PC);
            ifid_valid   <= 1'b0;
            ifid_instr   <= '0;
            idex_write   <= 1'b0;
            idex_use_imm <= 1'b0;
            idex_alu     <= ALU_ADD;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_dest    <= '0;
            idex_a       <= '0;
            idex_b       <= '0;
            idex_imm     <= '0;
            wb_valid     <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
        end else if (en) begin
            pc           <= pc + PC_W'(PC_STEP);
            ifid_valid   <= 1'b1;
            ifid_instr   <= instr;
            idex_write   <= id_write;
            idex_use_imm <= id_use_imm;
            idex_alu     <= id_alu;
            idex_rs      <= id_rs;
            idex_rt      <= id_rt;
            idex_dest    <= id_dest;
            idex_a       <= id_a;
            idex_b       <= id_b;
            idex_imm     <= id_imm_ext;
            wb_valid     <= idex_write;
            wb_reg       <= idex_write ? idex_dest : 5'd0;
            wb_data      <= idex_write ? ex_res : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (en && wb_valid) begin
            rf[wb_reg] <= wb_data;
        end
    end

    assign pc_out = pc;
    assign result = wb_valid ? wb_data : '0;

endmodule

// File: tb/tb_mips_pipe_datapath.sv
// Directed self-checking bench for mips_pipe_datapath: instruction words are driven straight onto instr,
// and each write-back is compared with hand-computed values three issues later.
module tb_mips_pipe_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] result;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_pc = 32'd0;

    always #5 clk = ~clk;

    mips_pipe_datapath #(
        .DW(32),
        .PC_W(32),
        .PC_STEP(4),
        .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .instr(instr),
        .pc_out(pc_out),
        .wb_valid(wb_valid),
        .wb_reg(wb_reg),
        .result(result)
    );

    // Present one word for the next edge, then settle just after it.
    task automatic issue(input logic [31:0] w);
        instr = w;
        @(posedge clk);
        #1;
        if (en) exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        en    = 1'b1;
        instr = 32'd0;
        #12;
        checks++;
        if (pc_out !== 32'd0 || wb_valid !== 1'b0 || wb_reg !== 5'd0 || result !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset: pc=%h valid=%b reg=%0d result=%h, want pc=0 valid=0 reg=0 result=0",
                     pc_out, wb_valid, wb_reg, result);
        end
        rst    = 1'b1;
        exp_pc = 32'd0;
    endtask

    task automatic test_forwarding();
        logic [31:0] prog [2];
        logic [4:0]  ereg [2];
        logic [31:0] eres [2];
        prog[0] = 32'h20010005; ereg[0] = 5'd1; eres[0] = 32'd5;
        prog[1] = 32'h20220003; ereg[1] = 5'd2; eres[1] = 32'd8;
        for (int i = 0; i < 4; i++) begin
            issue(i < 2 ? prog[i] : 32'd0);
            if (i >= 2) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_reg !== ereg[i-2] || result !== eres[i-2]) begin
                    fails++;
                    $display("[TB] FAIL forward[%0d]: valid=%b reg=%0d result=%h, want valid=1 reg=%0d result=%h",
                             i-2, wb_valid, wb_reg, result, ereg[i-2], eres[i-2]);
                end
            end
        end
        checks++;
        if (pc_out !== exp_pc) begin
            fails++;
            $display("[TB] FAIL pc_step: pc=%h want %h", pc_out, exp_pc);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] prog [3];
        logic        eval [3];
        logic [4:0]  ereg [3];
        logic [31:0] eres [3];
        prog[0] = 32'h20010007; eval[0] = 1'b1; ereg[0] = 5'd1; eres[0] = 32'd7;
        prog[1] = 32'h00000000; eval[1] = 1'b0; ereg[1] = 5'd0; eres[1] = 32'd0;
        prog[2] = 32'h00211820; eval[2] = 1'b1; ereg[2] = 5'd3; eres[2] = 32'd14;
        for (int i = 0; i < 5; i++) begin
            issue(i < 3 ? prog[i] : 32'd0);
            if (i >= 2) begin
                checks++;
                if (wb_valid !== eval[i-2] || result !== eres[i-2] || (eval[i-2] && wb_reg !== ereg[i-2])) begin
                    fails++;
                    $display("[TB] FAIL bypass[%0d]: valid=%b reg=%0d result=%h, want valid=%b reg=%0d result=%h",
                             i-2, wb_valid, wb_reg, result, eval[i-2], ereg[i-2], eres[i-2]);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] prog [2];
        logic        eval [2];
        logic [4:0]  ereg [2];
        prog[0] = 32'h20000009; eval[0] = 1'b0; ereg[0] = 5'd0;
        prog[1] = 32'h00002020; eval[1] = 1'b1; ereg[1] = 5'd4;
        for (int i = 0; i < 4; i++) begin
            issue(i < 2 ? prog[i] : 32'd0);
            if (i >= 2) begin
                checks++;
                if (wb_valid !== eval[i-2] || result !== 32'd0 || (eval[i-2] && wb_reg !== ereg[i-2])) begin
                    fails++;
                    $display("[TB] FAIL zero_reg[%0d]: valid=%b reg=%0d result=%h, want valid=%b reg=%0d result=0",
                             i-2, wb_valid, wb_reg, result, eval[i-2], ereg[i-2]);
                end
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [11];
        logic        eval [11];
        logic [4:0]  ereg [11];
        logic [31:0] eres [11];
        prog[0]  = 32'h20010005; eval[0]  = 1'b1; ereg[0]  = 5'd1;  eres[0]  = 32'd5;
        prog[1]  = 32'h20020008; eval[1]  = 1'b1; ereg[1]  = 5'd2;  eres[1]  = 32'd8;
        prog[2]  = 32'h0022182A; eval[2]  = 1'b1; ereg[2]  = 5'd3;  eres[2]  = 32'd1;
        prog[3]  = 32'h00221822; eval[3]  = 1'b1; ereg[3]  = 5'd3;  eres[3]  = 32'hFFFFFFFD;
        prog[4]  = 32'h3C010001; eval[4]  = 1'b0; ereg[4]  = 5'd0;  eres[4]  = 32'd0;
        prog[5]  = 32'h00222824; eval[5]  = 1'b1; ereg[5]  = 5'd5;  eres[5]  = 32'd0;
        prog[6]  = 32'h00223025; eval[6]  = 1'b1; ereg[6]  = 5'd6;  eres[6]  = 32'd13;
        prog[7]  = 32'h0041382A; eval[7]  = 1'b1; ereg[7]  = 5'd7;  eres[7]  = 32'd0;
        prog[8]  = 32'h2008FFFF; eval[8]  = 1'b1; ereg[8]  = 5'd8;  eres[8]  = 32'hFFFFFFFF;
        prog[9]  = 32'h0101482A; eval[9]  = 1'b1; ereg[9]  = 5'd9;  eres[9]  = 32'd1;
        prog[10] = 32'h210A0001; eval[10] = 1'b1; ereg[10] = 5'd10; eres[10] = 32'd0;
        for (int i = 0; i < 13; i++) begin
            issue(i < 11 ? prog[i] : 32'd0);
            if (i >= 2) begin
                checks++;
                if (wb_valid !== eval[i-2] || result !== eres[i-2] || (eval[i-2] && wb_reg !== ereg[i-2])) begin
                    fails++;
                    $display("[TB] FAIL alu[%0d]: valid=%b reg=%0d result=%h, want valid=%b reg=%0d result=%h",
                             i-2, wb_valid, wb_reg, result, eval[i-2], ereg[i-2], eres[i-2]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [4:0]  ereg [3];
        logic [31:0] eres [3];
        issue(32'h200B0003);
        issue(32'h216C0004);
        issue(32'h016C6820);
        checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd11 || result !== 32'd3) begin
            fails++;
            $display("[TB] FAIL freeze_pre: valid=%b reg=%0d result=%h, want valid=1 reg=11 result=3",
                     wb_valid, wb_reg, result);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(32'h20010063);
            checks++;
            if (pc_out !== exp_pc || wb_valid !== 1'b1 || wb_reg !== 5'd11 || result !== 32'd3) begin
                fails++;
                $display("[TB] FAIL freeze_hold[%0d]: pc=%h valid=%b reg=%0d result=%h, want pc=%h valid=1 reg=11 result=3",
                         i, pc_out, wb_valid, wb_reg, result, exp_pc);
            end
        end
        en = 1'b1;
        ereg[0] = 5'd12; eres[0] = 32'd7;
        ereg[1] = 5'd13; eres[1] = 32'd10;
        ereg[2] = 5'd14; eres[2] = 32'd5;
        for (int i = 0; i < 3; i++) begin
            issue(i == 0 ? 32'h00207020 : 32'd0);
            checks++;
            if (wb_valid !== 1'b1 || wb_reg !== ereg[i] || result !== eres[i]) begin
                fails++;
                $display("[TB] FAIL freeze_resume[%0d]: valid=%b reg=%0d result=%h, want valid=1 reg=%0d result=%h",
                         i, wb_valid, wb_reg, result, ereg[i], eres[i]);
            end
        end
        checks++;
        if (pc_out !== exp_pc) begin
            fails++;
            $display("[TB] FAIL freeze_pc: pc=%h want %h", pc_out, exp_pc);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] w;
        issue(32'h200F0011);
        issue(32'h20100022);
        issue(32'h20110033);
        issue(32'd0);
        issue(32'd0);
        issue(32'h20120044);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'd0 || wb_valid !== 1'b0 || result !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid: pc=%h valid=%b result=%h, want pc=0 valid=0 result=0",
                     pc_out, wb_valid, result);
        end
        #2;
        rst    = 1'b1;
        exp_pc = 32'd0;
        for (int r = 1; r < 34; r++) begin
            w = (r < 32) ? ((32'(r) << 21) | (32'(r) << 11) | 32'h20) : 32'd0;
            issue(w);
            if (r >= 3) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_reg !== 5'(r - 2) || result !== 32'd0) begin
                    fails++;
                    $display("[TB] FAIL readback[%0d]: valid=%b reg=%0d result=%h, want valid=1 reg=%0d result=0",
                             r - 2, wb_valid, wb_reg, result, r - 2);
                end
            end
        end
        checks++;
        if (pc_out !== exp_pc) begin
            fails++;
            $display("[TB] FAIL reset_pc: pc=%h want %h", pc_out, exp_pc);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_bypass();
        test_zero_reg();
        test_alu_ops();
        test_freeze();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mips_pipe_datapath.md
Name: mips_pipe_datapath

Overview:
Parametrised 4-stage pipelined integer datapath (IF, ID, EX, WB) with an internal register file, ALU, sign-extender, decoder and forwarding. It succeeds the single-cycle datapath top. The mux selects and ALU op that were external pins are now decoded internally from the instruction word. Instruction memory stays external: combinational read, addressed by pc_out.

Parameters:
DW, 32, datapath/register width (≥16); immediates sign-extend to DW
PC_W, 32, program-counter width
PC_STEP, 4, PC increment per fetch
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
en  in  1  global advance; low freezes PC, all pipeline registers and register-file writes
instr  in  32  instruction word at pc_out (combinational from memory)
pc_out  out  PC_W  fetch address
wb_valid  out  1  WB stage holds an instruction that writes a register
wb_reg  out  5  WB destination register
result  out  DW  WB write data (0 when wb_valid=0)

Behaviour:
- Reset, asynchronous, while rst=0:
  - pc_out=RESET_PC.
  - All stage valid bits cleared; wb_valid=0, wb_reg=0, result=0.
  - All 32 registers cleared to 0.
  - Takes effect mid-operation; in-flight instructions are discarded.
- Supported instructions; anything else decodes as a bubble (no write):
  - R-type (op=0) by funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed).
  - ADDI (op=0x08).
- Destination and operand B:
  - R-type: dest=rd, ALU B=rs_t value.
  - ADDI: dest=rt, ALU B=sign-extended imm16.
- Arithmetic: modulo 2^DW, no overflow trap. SLT result is 1 or 0, zero-extended to DW.
- Register 0 reads as 0. Writes to $0 are dropped, and $0 is never a bypass/forward source. An instruction targeting $0 reaches WB with wb_valid=0.
- Pipeline, on each edge with en=1:
  - PC += PC_STEP.
  - IF/ID ← instr.
  - ID/EX ← decoded ctrl, operands, dest.
  - EX/WB ← ALU result.
  - The register file writes EX/WB data when wb_valid=1.
- Latency: an instruction fetched in cycle n drives wb_valid/result in cycle n+3. Its register-file write completes at the end of cycle n+3. Throughput is 1 instruction/cycle with no stalls.
- Hazards, resolved without bubbles:
  - EX source equals the WB dest (≠0, wb_valid=1): forward the EX/WB result to that ALU operand.
  - ID read register equals the same-cycle WB write: write-through bypass returns the new value.
  - Both paths active on different operands: each resolves independently.
- en=0: all state holds, including PC and the register file. Outputs hold their values. Reset overrides en.
- PC wraps modulo 2^PC_W.

Optional Feature:
MIPS_PIPE_SHIFT_EN:
- Defined: adds R-type SLL (funct 0x00) and SRL (funct 0x02), logical shift of the rt value by shamt[4:0]. Shift amounts ≥DW give 0.
- Undefined: both functs decode as bubbles. Forwarding is unchanged either way.
- Word 0x00000000 is a no-write in both builds, because its dest is $0.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst=0 asynchronously mid-clock after several ADDIs, then release and read back.
  - Required: pc_out=0, wb_valid=0, result=0 immediately; all registers read 0 afterward.
- EX→EX forwarding:
  - Stimulus: 0x20010005 (ADDI $1,$0,5) then 0x20220003 (ADDI $2,$1,3).
  - Required: consecutive WB cycles give wb_reg=1/result=5, then wb_reg=2/result=8, with no bubble.
- Write-through bypass:
  - Stimulus: 0x20010007, 0x00000000, 0x00211820 (ADD $3,$1,$1).
  - Required: third WB gives wb_reg=3, result=14.
- $0 protection:
  - Stimulus: 0x20000009 then 0x00002020 (ADD $4,$0,$0).
  - Required: first WB has wb_valid=0; second gives wb_reg=4, result=0.
- Signed ALU ops, with $1=5, $2=8:
  - 0x0022182A (SLT) → result=1.
  - 0x00221822 (SUB) → result=0xFFFFFFFD.
  - Unsupported op 0x3C010001 → wb_valid=0.
- Freeze:
  - Stimulus: drop en for 3 cycles while 3 instructions are in flight.
  - Required: pc_out, wb_reg and result constant and no register changes; on en=1 the results emerge in original order with correct values.
